alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  - Upstream issue/capture stage for the 4-bit combinational alu (operands A,B, select S; outputs y, Cout).
//  - Accepts ALU commands over a valid/ready handshake and registers A/B/S into the alu.
//  - Captures y/Cout one cycle later and presents the result over a second valid/ready handshake.
//  - Counts completed operations; flags illegal selects.
// PARAMETERS
//  - WIDTH   4   operand/result width; must match the alu
//  - CNT_W   8   width of the completed-operation counter
//  - OP_MAX  13  highest legal select code (0..13 = the alu's 14 operations)
// PORTS
//  - clk        in   1      rising-edge clock
//  - rst        in   1      asynchronous, active-high reset
//  - cmd_valid  in   1      command present
//  - cmd_ready  out  1      sequencer accepts command this cycle
//  - cmd_a      in   WIDTH  operand A
//  - cmd_b      in   WIDTH  operand B
//  - cmd_s      in   4      operation select
//  - cmd_acc    in   1      use accumulator as A (honoured only with ALU_ACC_EN)
//  - alu_a      out  WIDTH  registered A to alu
//  - alu_b      out  WIDTH  registered B to alu
//  - alu_s      out  4      registered S to alu
//  - alu_y      in   WIDTH  alu result y
//  - alu_cout   in   1      alu carry-out
//  - res_valid  out  1      result held
//  - res_ready  in   1      consumer takes result
//  - res_y      out  WIDTH  captured result
//  - res_cout   out  1      captured carry
//  - res_err    out  1      command had cmd_s > OP_MAX
//  - op_count   out  CNT_W  completed results (res handshakes), wraps
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE; acc = 0. Reset is asynchronous and takes effect mid-operation: in-flight command discarded, no result produced.
//  - FSM states:
//    - IDLE: cmd_ready = 1.
//    - EXEC: cmd_ready = 0; alu settling.
//    - DONE: res_valid = 1; cmd_ready = res_ready.
//  - Accept = cmd_valid & cmd_ready at an edge. Accept registers alu_a/alu_b/alu_s and moves to EXEC.
//  - EXEC -> DONE unconditionally. At that edge: res_y <= alu_y, res_cout <= alu_cout, res_err <= (alu_s > OP_MAX).
//  - Illegal select: alu_s still driven as given; res_y forced 0 and res_cout forced 0 when res_err = 1.
//  - DONE with res_ready & cmd_valid: result retires and new command accepted at the same edge -> EXEC.
//  - DONE with res_ready & !cmd_valid: -> IDLE.
//  - DONE with !res_ready: hold. All res_* stable; alu_* stable.
//  - Latency: accept at edge k -> res_valid = 1 after edge k+1. Peak throughput: 1 op per 2 cycles.
//  - op_count increments on every res handshake, including errors; wraps 2^CNT_W-1 -> 0.
//  - alu_* change only on accept; res_* change only at EXEC->DONE.
// CONFIGURATION
//  - Macro ALU_ACC_EN defined:
//    - acc register loads res_y at every EXEC->DONE with res_err = 0.
//    - On accept with cmd_acc = 1, alu_a <= acc (cmd_a ignored).
//    - acc is cleared only by reset.
//  - Macro ALU_ACC_EN undefined: cmd_acc ignored; no acc register; alu_a <= cmd_a always.
// STRUCTURE
//  - Package alu_seq_pkg: WIDTH default, OP_MAX, state encodings (IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2), opcode constant OP_ILLEGAL_MIN = 4'd14.
//  - One sub-module: alu_op_counter (CNT_W wrap counter, enable = res handshake).
//  - alu is instantiated by the parent, not inside this block.
// TESTING
//  - Basic: reset; A = 9, B = 1, S = 0 with stub alu_y = 4'hA, cout = 0 -> alu_s = 0 after accept edge, res_valid one edge later, res_y = A, op_count = 1 after res_ready.
//  - Back-to-back: res_ready held 1, commands S = 12 then S = 9 continuous -> second accepted in DONE cycle, results 2 cycles apart, cmd_ready never low twice in a row.
//  - Backpressure: res_ready = 0 for 5 cycles -> res_valid/res_y/alu_* stable, cmd_ready = 0; release -> single retire.
//  - Illegal: S = 4'hF -> res_err = 1, res_y = 0, res_cout = 0; op_count still increments.
//  - Reset mid-op: assert rst during EXEC -> all outputs 0 immediately, no result after deassert.
//  - ALU_ACC_EN: op1 result 4'h3, op2 cmd_acc = 1, cmd_a = 4'hF -> alu_a = 4'h3; without macro alu_a = 4'hF.
//  - Wrap: 256 ops with CNT_W = 8 -> op_count = 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared defaults, FSM state encodings and opcode limits for the alu sequencer.
package alu_seq_pkg;
   localparam int         WIDTH_DEF      = 4;
   localparam int         OP_MAX_DEF     = 13;
   localparam logic [1:0] IDLE           = 2'd0;
   localparam logic [1:0] EXEC           = 2'd1;
   localparam logic [1:0] DONE           = 2'd2;
   localparam logic [3:0] OP_ILLEGAL_MIN = 4'd14;
endpackage

// File: rtl/alu_op_counter.sv
// alu_op_counter: wrapping counter of completed result handshakes.
module alu_op_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_count
);
   always_ff @(posedge clk or posedge rst)
      if (rst) o_count <= '0;
      else if (i_en) o_count <= o_count + 1'b1;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues handshaked commands to a combinational alu and captures its result.
// Optional accumulator feedback for operand A is enabled by defining ALU_ACC_EN.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int CNT_W  = 8,
   parameter int OP_MAX = OP_MAX_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [3:0]       cmd_s,
   input  logic             cmd_acc,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_s,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_cout,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_y,
   output logic             res_cout,
   output logic             res_err,
   output logic [CNT_W-1:0] op_count
);
   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic             w_accept;
   logic             w_retire;
   logic             w_err;
   logic [WIDTH-1:0] w_a;

   assign cmd_ready = (r_state == IDLE) | ((r_state == DONE) & res_ready);
   assign res_valid = r_state == DONE;
   assign w_accept  = cmd_valid & cmd_ready;
   assign w_retire  = res_valid & res_ready;
   assign w_err     = alu_s > 4'(OP_MAX);

   always_comb
      w_next = (r_state == EXEC) ? DONE :
               ((r_state == DONE) & !res_ready) ? DONE :
               w_accept ? EXEC : IDLE;

`ifdef ALU_ACC_EN
   logic [WIDTH-1:0] r_acc;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_acc <= '0;
      else if ((r_state == EXEC) && !w_err) r_acc <= alu_y;
   assign w_a = cmd_acc ? r_acc : cmd_a;
`else
   logic w_unused_acc;
   assign w_unused_acc = cmd_acc;
   assign w_a = cmd_a;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state  <= IDLE;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_s    <= '0;
         res_y    <= '0;
         res_cout <= 1'b0;
         res_err  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            alu_a <= w_a;
            alu_b <= cmd_b;
            alu_s <= cmd_s;
         end
         // illegal selects still reach the alu, but their result is masked here
         if (r_state == EXEC) begin
            res_y    <= w_err ? '0 : alu_y;
            res_cout <= w_err ? 1'b0 : alu_cout;
            res_err  <= w_err;
         end
      end

   alu_op_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_retire),
      .o_count(op_count)
   );
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks against a transaction-level reference model.
module tb_alu_op_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid, cmd_ready, cmd_acc;
   logic [3:0] cmd_a, cmd_b, cmd_s;
   logic [3:0] alu_a, alu_b, alu_s, alu_y;
   logic       alu_cout;
   logic       res_valid, res_ready, res_cout, res_err;
   logic [3:0] res_y;
   logic [7:0] op_count;
   int         checks = 0;
   int         errors = 0;
   int         exp_cnt = 0;

   logic       stub_fix = 1'b1;
   logic [3:0] fix_y = 4'h0;
   logic       fix_c = 1'b0;

   always #5 clk = ~clk;

   // stand-in alu: either a forced value or a simple add of a, b and s
   always_comb {alu_cout, alu_y} = stub_fix ? {fix_c, fix_y} : 5'(alu_a) + 5'(alu_b) + 5'(alu_s);

   alu_op_sequencer #(.WIDTH(4), .CNT_W(8), .OP_MAX(13)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s), .cmd_acc(cmd_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y), .alu_cout(alu_cout),
      .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_cout(res_cout),
      .res_err(res_err), .op_count(op_count)
   );

   function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
      return (s > 4'd13) ? 5'd0 : 5'(a) + 5'(b) + 5'(s);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_s = s; res_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      exp_cnt++;
   endtask

   initial begin
      logic       m_pend, m_hold, m_ready, acc, ret, he;
      logic [3:0] pa, pb, ps, na, nb, ns;
      logic [4:0] hv;
      cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_s = '0; cmd_acc = 1'b0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_y", res_y, 0);
      chk("rst_res_cout", res_cout, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_s", alu_s, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      rst = 1'b0;
      tick();

      // basic op plus backpressure on the result side
      fix_y = 4'hA; fix_c = 1'b0;
      cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd1; cmd_s = 4'd0;
      tick();
      chk("basic_alu_a", alu_a, 9);
      chk("basic_alu_b", alu_b, 1);
      chk("basic_alu_s", alu_s, 0);
      chk("basic_exec_valid", res_valid, 0);
      chk("basic_exec_ready", cmd_ready, 0);
      cmd_valid = 1'b0;
      tick();
      chk("basic_res_valid", res_valid, 1);
      chk("basic_res_y", res_y, 4'hA);
      chk("basic_res_cout", res_cout, 0);
      chk("basic_res_err", res_err, 0);
      chk("basic_cnt_before", op_count, 0);
      fix_y = 4'h5;
      cmd_valid = 1'b1; cmd_a = 4'd7; cmd_s = 4'd2;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_res_valid", res_valid, 1);
         chk("bp_res_y", res_y, 4'hA);
         chk("bp_alu_a", alu_a, 9);
         chk("bp_alu_s", alu_s, 0);
         chk("bp_cmd_ready", cmd_ready, 0);
      end
      cmd_valid = 1'b0; res_ready = 1'b1;
      #1;
      chk("bp_release_ready", cmd_ready, 1);
      tick();
      exp_cnt++;
      chk("bp_retire_cnt", op_count, exp_cnt);
      chk("bp_retire_valid", res_valid, 0);
      res_ready = 1'b0;
      tick();
      chk("bp_single_retire", op_count, exp_cnt);

      // illegal select masks the alu result but still counts
      fix_y = 4'hA; fix_c = 1'b1;
      cmd_valid = 1'b1; cmd_a = 4'd1; cmd_b = 4'd2; cmd_s = 4'hF;
      tick();
      chk("ill_alu_s", alu_s, 4'hF);
      cmd_valid = 1'b0;
      tick();
      chk("ill_res_valid", res_valid, 1);
      chk("ill_res_err", res_err, 1);
      chk("ill_res_y", res_y, 0);
      chk("ill_res_cout", res_cout, 0);
      res_ready = 1'b1;
      tick();
      exp_cnt++;
      chk("ill_cnt", op_count, exp_cnt);

      // back-to-back issue with res_ready held high
      stub_fix = 1'b0;
      cmd_valid = 1'b1; cmd_a = 4'd3; cmd_b = 4'd4; cmd_s = 4'd12;
      tick();
      chk("b2b_alu_s1", alu_s, 12);
      chk("b2b_exec1_ready", cmd_ready, 0);
      cmd_a = 4'd5; cmd_b = 4'd6; cmd_s = 4'd9;
      tick();
      chk("b2b_res1_valid", res_valid, 1);
      chk("b2b_res1_y", res_y, 4'h3);
      chk("b2b_res1_cout", res_cout, 1);
      chk("b2b_done_ready", cmd_ready, 1);
      tick();
      exp_cnt++;
      chk("b2b_alu_s2", alu_s, 9);
      chk("b2b_exec2_valid", res_valid, 0);
      chk("b2b_cnt1", op_count, exp_cnt);
      cmd_valid = 1'b0;
      tick();
      chk("b2b_res2_valid", res_valid, 1);
      chk("b2b_res2_y", res_y, 4'h4);
      chk("b2b_res2_cout", res_cout, 1);
      tick();
      exp_cnt++;
      chk("b2b_cnt2", op_count, exp_cnt);

      // accumulator feedback for operand A
      stub_fix = 1'b1; fix_y = 4'h3; fix_c = 1'b0;
      do_op(4'd1, 4'd2, 4'd0);
      cmd_valid = 1'b1; cmd_acc = 1'b1; cmd_a = 4'hF;
      tick();
`ifdef ALU_ACC_EN
      chk("acc_alu_a", alu_a, 4'h3);
`else
      chk("acc_alu_a", alu_a, 4'hF);
`endif
      cmd_valid = 1'b0; cmd_acc = 1'b0;
      tick();
      tick();
      exp_cnt++;
      chk("acc_cnt", op_count, exp_cnt);

      // randomized traffic against a transaction-level model
      stub_fix = 1'b0;
      m_pend = 1'b0; m_hold = 1'b0; pa = '0; pb = '0; ps = '0; hv = '0; he = 1'b0;
      for (int i = 0; i < 300; i++) begin
         cmd_valid = (i >= 296) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
         res_ready = (i >= 296) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
         cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_s = 4'($urandom);
         #1;
         m_ready = !m_pend && (!m_hold || res_ready);
         chk("rnd_cmd_ready", cmd_ready, m_ready);
         chk("rnd_res_valid", res_valid, m_hold);
         chk("rnd_op_count", op_count, 8'(exp_cnt));
         if (m_hold) begin
            chk("rnd_res_y", res_y, hv[3:0]);
            chk("rnd_res_cout", res_cout, hv[4]);
            chk("rnd_res_err", res_err, he);
         end
         acc = cmd_valid && m_ready;
         ret = m_hold && res_ready;
         na = cmd_a; nb = cmd_b; ns = cmd_s;
         tick();
         if (ret) begin
            exp_cnt++;
            m_hold = 1'b0;
         end
         if (m_pend) begin
            m_hold = 1'b1;
            hv = ref_alu(pa, pb, ps);
            he = ps > 4'd13;
         end
         m_pend = acc;
         if (acc) begin
            pa = na; pb = nb; ps = ns;
            chk("rnd_alu_a", alu_a, pa);
            chk("rnd_alu_s", alu_s, ps);
         end
      end

      // asynchronous reset while a command is executing
      cmd_valid = 1'b1; res_ready = 1'b1; cmd_a = 4'd3; cmd_b = 4'd3; cmd_s = 4'd1;
      tick();
      cmd_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_alu_a", alu_a, 0);
      chk("mid_rst_alu_s", alu_s, 0);
      chk("mid_rst_res_y", res_y, 0);
      chk("mid_rst_cnt", op_count, 0);
      chk("mid_rst_ready", cmd_ready, 1);
      #1 rst = 1'b0;
      exp_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_valid", res_valid, 0);
         chk("post_rst_cnt", op_count, 0);
      end

      // counter wrap after 256 completed ops
      for (int i = 0; i < 256; i++) begin
         do_op(4'($urandom), 4'($urandom), 4'($urandom));
         if (i == 254) chk("wrap_cnt_255", op_count, 255);
      end
      chk("wrap_cnt_0", op_count, 0);
      chk("wrap_total", exp_cnt, 256);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
